exe_md_stage: RTL and testbench
===============================

EXE_MD_STAGE -- requirements
Module: exe_md_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be even and >= 8.
REQ-002 Parameter MUL_LAT, default 2, multiply busy cycles; legal range 1..4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 id_valid_in  input  1  upstream instruction valid.
REQ-006 exe_allowin_out  output  1  stage can accept an instruction this cycle.
REQ-007 mem_allowin_in  input  1  downstream can accept.
REQ-008 exe_valid_out  output  1  stage holds a completed instruction.
REQ-009 flush_in  input  1  kill the instruction in this stage.
REQ-010 id_aluop_in  input  12  one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
REQ-011 id_src0_in, id_src1_in  input  DATA_W each  operands.
REQ-012 id_md_op_in  input  6  one-hot {mult, multu, div, divu, mthi, mtlo}; all zero means non-MD.
REQ-013 id_rd_hilo_in  input  2  {mfhi, mflo}; at most one bit set.
REQ-014 id_regnum_in  input  5  destination register, passed through.
REQ-015 exe_res_out  output  DATA_W  ALU result, or HI/LO for mfhi/mflo.
REQ-016 exe_regnum_out  output  5  registered id_regnum_in.
REQ-017 exe_hi_out, exe_lo_out  output  DATA_W each  architectural HI/LO.
REQ-018 exe_busy_out  output  1  high while the FSM is in MUL or DIV.

Function
REQ-019 allowin SHALL equal !valid_r || (ready && mem_allowin_in); exe_valid_out SHALL equal valid_r && ready && !flush_in.
REQ-020 The stage registers SHALL capture all id_* inputs when allowin && id_valid_in; valid_r SHALL load id_valid_in when allowin.
REQ-021 ALU result SHALL be combinational from the registered operands; shifts SHALL use src0[log2(DATA_W)-1:0] as amount and src1 as data; lui SHALL give src1 << DATA_W/2.
REQ-022 FSM states SHALL be IDLE, MUL, DIV and DONE; ready SHALL be 0 in MUL and DIV and 1 in IDLE and DONE.
REQ-023 On capture of mult/multu, the FSM SHALL go IDLE->MUL, stay MUL_LAT cycles, then go to DONE.
REQ-024 On capture of div/divu, the FSM SHALL go IDLE->DIV, run a restoring radix-2 divider for exactly DATA_W cycles, then go to DONE.
REQ-025 On the MUL->DONE or DIV->DONE transition, HI/LO SHALL be written once: mult gives {HI,LO}=2*DATA_W-bit product; div gives LO=quotient, HI=remainder.
REQ-026 Signed division SHALL truncate toward zero, with the remainder taking the dividend's sign.
REQ-027 Division by zero SHALL give LO all-ones and HI equal to the dividend, for both signed and unsigned division.
REQ-028 DONE SHALL return to IDLE when mem_allowin_in is 1; it SHALL hold otherwise. A new MD op captured in the same cycle SHALL enter MUL or DIV directly.
REQ-029 mthi/mtlo SHALL write src0 into HI/LO in the cycle the instruction leaves (valid_r && ready && mem_allowin_in && !flush_in).
REQ-030 mfhi/mflo SHALL read current HI/LO; a read immediately after an MD op SHALL see the new value, with no extra stall.
REQ-031 flush_in SHALL clear valid_r, force the FSM to IDLE and abort any divide or multiply; it SHALL suppress every HI/LO write in that cycle.
REQ-032 When flush_in and id_valid_in are both high, the flush SHALL win and the incoming instruction SHALL be dropped.
REQ-033 A non-MD instruction SHALL take exactly one cycle in the stage when mem_allowin_in is 1.

Reset
REQ-034 While rst_n is 0, valid_r, FSM=IDLE, iteration counter, HI, LO, all stage registers and all outputs SHALL be zero, and exe_allowin_out SHALL be 1.
REQ-035 Reset during MUL or DIV SHALL abandon the operation with no HI/LO write.

Configuration
REQ-036 Macro EXE_DIV_SKIP_EN: when defined, a divide whose divisor is zero or |dividend| < |divisor| SHALL complete after 1 DIV cycle with the REQ-026/027 results.
REQ-037 When EXE_DIV_SKIP_EN is undefined, every divide SHALL take exactly DATA_W DIV cycles.

Verification
REQ-038 add 7,5, mem_allowin_in=1 -> exe_valid_out next cycle, exe_res_out=12, no stall.
REQ-039 mult -3 x 4, MUL_LAT=2 -> busy 2 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF4; a following mflo returns 0xFFFFFFF4.
REQ-040 div -7 / 2 -> 32 busy cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-041 flush_in asserted at DIV cycle 10 -> FSM IDLE next cycle, HI/LO unchanged, exe_allowin_out=1.
REQ-042 mem_allowin_in=0 for 3 cycles in DONE -> exe_valid_out held high, HI/LO written exactly once.
REQ-043 With EXE_DIV_SKIP_EN defined, divu 3/9 -> 1 busy cycle, LO=0, HI=3.

Source files
------------

// File: rtl/exe_md_stage.sv
// Execute stage: combinational ALU plus an iterative multiply/divide unit that owns HI/LO.
// Macro EXE_DIV_SKIP_EN: trivial divides (zero divisor or |dividend| < |divisor|) finish after one DIV cycle.
// Bit orders: id_aluop_in[0]=add .. [11]=lui; id_md_op_in={mult,multu,div,divu,mthi,mtlo}; id_rd_hilo_in={mfhi,mflo}.
module exe_md_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_in,
  output logic              exe_allowin_out,
  input  logic              mem_allowin_in,
  output logic              exe_valid_out,
  input  logic              flush_in,
  input  logic [11:0]       id_aluop_in,
  input  logic [DATA_W-1:0] id_src0_in,
  input  logic [DATA_W-1:0] id_src1_in,
  input  logic [5:0]        id_md_op_in,
  input  logic [1:0]        id_rd_hilo_in,
  input  logic [4:0]        id_regnum_in,
  output logic [DATA_W-1:0] exe_res_out,
  output logic [4:0]        exe_regnum_out,
  output logic [DATA_W-1:0] exe_hi_out,
  output logic [DATA_W-1:0] exe_lo_out,
  output logic              exe_busy_out
);

  localparam int unsigned MD_MULT  = 5;
  localparam int unsigned MD_MULTU = 4;
  localparam int unsigned MD_DIV   = 3;
  localparam int unsigned MD_DIVU  = 2;
  localparam int unsigned MD_MTHI  = 1;
  localparam int unsigned MD_MTLO  = 0;
  localparam int unsigned MSB      = DATA_W - 1;
  localparam int unsigned SH_W     = $clog2(DATA_W);
  localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
  localparam int unsigned PW       = 2 * DATA_W;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q;
  logic [11:0]       aluop_q;
  logic [DATA_W-1:0] src0_q, src1_q;
  logic [5:0]        md_op_q;
  logic [1:0]        rd_hilo_q;
  logic [4:0]        regnum_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;

  logic ready, capture, leave, cap_mul, cap_div;
  logic mul_fin, div_last, div_wr, skip;

  // Handshake
  assign ready           = (state_q == S_IDLE) || (state_q == S_DONE);
  assign exe_allowin_out = !valid_q || (ready && mem_allowin_in);
  assign exe_valid_out   = valid_q && ready && !flush_in;
  assign exe_busy_out    = (state_q == S_MUL) || (state_q == S_DIV);
  assign capture         = exe_allowin_out && id_valid_in && !flush_in;
  assign leave           = valid_q && ready && mem_allowin_in && !flush_in;
  assign cap_mul         = capture && (id_md_op_in[MD_MULT] || id_md_op_in[MD_MULTU]);
  assign cap_div         = capture && (id_md_op_in[MD_DIV] || id_md_op_in[MD_DIVU]);

`ifdef EXE_DIV_SKIP_EN
  // On the first DIV cycle quo_q still holds |dividend| and rem_q is zero.
  assign skip = (cnt_q == '0) && ((dvs_q == '0) || (quo_q < dvs_q));
`else
  assign skip = 1'b0;
`endif

  assign mul_fin  = (state_q == S_MUL) && (cnt_q == MUL_LAST) && !flush_in;
  assign div_last = (state_q == S_DIV) && ((cnt_q == DIV_LAST) || skip);
  assign div_wr   = div_last && !flush_in;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cap_mul)      state_d = S_MUL;
        else if (cap_div) state_d = S_DIV;
      end
      S_MUL: if (cnt_q == MUL_LAST) state_d = S_DONE;
      S_DIV: if (div_last)          state_d = S_DONE;
      S_DONE: begin
        if (mem_allowin_in) begin
          if (cap_mul)      state_d = S_MUL;
          else if (cap_div) state_d = S_DIV;
          else              state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_in) state_d = S_IDLE;
  end

  always_comb begin
    cnt_d = '0;
    if (exe_busy_out && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      aluop_q   <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      md_op_q   <= '0;
      rd_hilo_q <= '0;
      regnum_q  <= '0;
    end else begin
      if (flush_in)             valid_q <= 1'b0;
      else if (exe_allowin_out) valid_q <= id_valid_in;
      if (exe_allowin_out && id_valid_in) begin
        aluop_q   <= id_aluop_in;
        src0_q    <= id_src0_in;
        src1_q    <= id_src1_in;
        md_op_q   <= id_md_op_in;
        rd_hilo_q <= id_rd_hilo_in;
        regnum_q  <= id_regnum_in;
      end
    end
  end

  // ALU
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] sra_res, alu_res;
  logic              slt_s, slt_u;

  assign shamt   = src0_q[SH_W-1:0];
  assign sra_res = $signed(src1_q) >>> shamt;
  assign slt_s   = $signed(src0_q) < $signed(src1_q);
  assign slt_u   = src0_q < src1_q;

  assign alu_res = ({DATA_W{aluop_q[0]}}  & (src0_q + src1_q))
                 | ({DATA_W{aluop_q[1]}}  & (src0_q - src1_q))
                 | ({DATA_W{aluop_q[2]}}  & {{(DATA_W-1){1'b0}}, slt_s})
                 | ({DATA_W{aluop_q[3]}}  & {{(DATA_W-1){1'b0}}, slt_u})
                 | ({DATA_W{aluop_q[4]}}  & (src0_q & src1_q))
                 | ({DATA_W{aluop_q[5]}}  & ~(src0_q | src1_q))
                 | ({DATA_W{aluop_q[6]}}  & (src0_q | src1_q))
                 | ({DATA_W{aluop_q[7]}}  & (src0_q ^ src1_q))
                 | ({DATA_W{aluop_q[8]}}  & (src1_q << shamt))
                 | ({DATA_W{aluop_q[9]}}  & (src1_q >> shamt))
                 | ({DATA_W{aluop_q[10]}} & sra_res)
                 | ({DATA_W{aluop_q[11]}} & (src1_q << (DATA_W / 2)));

  assign exe_res_out    = rd_hilo_q[1] ? hi_q : (rd_hilo_q[0] ? lo_q : alu_res);
  assign exe_regnum_out = regnum_q;
  assign exe_hi_out     = hi_q;
  assign exe_lo_out     = lo_q;

  // Multiplier: product is formed from the held operands; MUL_LAT only paces the write.
  logic          mul_sgn;
  logic [PW-1:0] mul_a, mul_b, prod;

  assign mul_sgn = md_op_q[MD_MULT] && !md_op_q[MD_MULTU];
  assign mul_a   = {{DATA_W{mul_sgn & src0_q[MSB]}}, src0_q};
  assign mul_b   = {{DATA_W{mul_sgn & src1_q[MSB]}}, src1_q};
  assign prod    = mul_a * mul_b;

  // Restoring divider on magnitudes; sign fix-up applied when the result is written.
  logic              div_sgn, q_neg, r_neg, dvd_neg_in, dvs_neg_in;
  logic [DATA_W:0]   div_sh, div_diff;
  logic [DATA_W-1:0] rem_nx, quo_nx, div_hi, div_lo;

  assign dvd_neg_in = id_md_op_in[MD_DIV] && id_src0_in[MSB];
  assign dvs_neg_in = id_md_op_in[MD_DIV] && id_src1_in[MSB];
  assign div_sh     = {rem_q, quo_q[MSB]};
  assign div_diff   = div_sh - {1'b0, dvs_q};
  assign rem_nx     = div_diff[DATA_W] ? div_sh[DATA_W-1:0] : div_diff[DATA_W-1:0];
  assign quo_nx     = {quo_q[DATA_W-2:0], ~div_diff[DATA_W]};

  assign div_sgn = md_op_q[MD_DIV] && !md_op_q[MD_DIVU];
  assign q_neg   = div_sgn && (src0_q[MSB] ^ src1_q[MSB]);
  assign r_neg   = div_sgn && src0_q[MSB];

  always_comb begin
    div_lo = q_neg ? (~quo_nx + 1'b1) : quo_nx;
    div_hi = r_neg ? (~rem_nx + 1'b1) : rem_nx;
    if (src1_q == '0) begin
      div_lo = '1;
      div_hi = src0_q;
    end else if (skip) begin
      div_lo = '0;
      div_hi = src0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (cap_div) begin
      rem_q <= '0;
      quo_q <= dvd_neg_in ? (~id_src0_in + 1'b1) : id_src0_in;
      dvs_q <= dvs_neg_in ? (~id_src1_in + 1'b1) : id_src1_in;
    end else if (state_q == S_DIV) begin
      rem_q <= rem_nx;
      quo_q <= quo_nx;
    end
  end

  // HI/LO: one write on MUL/DIV completion, or mthi/mtlo as the instruction leaves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mul_fin) begin
      hi_q <= prod[PW-1:DATA_W];
      lo_q <= prod[DATA_W-1:0];
    end else if (div_wr) begin
      hi_q <= div_hi;
      lo_q <= div_lo;
    end else if (leave) begin
      if (md_op_q[MD_MTHI]) hi_q <= src0_q;
      if (md_op_q[MD_MTLO]) lo_q <= src0_q;
    end
  end

endmodule

// File: tb/tb_exe_md_stage.sv
// Scoreboard bench for exe_md_stage: results queued at issue, compared when the stage hands off.
module tb_exe_md_stage;
  localparam int W = 32;
`ifdef EXE_DIV_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid_in = 1'b0;
  logic          exe_allowin_out;
  logic          mem_allowin_in = 1'b1;
  logic          exe_valid_out;
  logic          flush_in = 1'b0;
  logic [11:0]   id_aluop_in = '0;
  logic [W-1:0]  id_src0_in = '0;
  logic [W-1:0]  id_src1_in = '0;
  logic [5:0]    id_md_op_in = '0;
  logic [1:0]    id_rd_hilo_in = '0;
  logic [4:0]    id_regnum_in = '0;
  logic [W-1:0]  exe_res_out;
  logic [4:0]    exe_regnum_out;
  logic [W-1:0]  exe_hi_out;
  logic [W-1:0]  exe_lo_out;
  logic          exe_busy_out;

  always #5 clk = ~clk;

  exe_md_stage #(.DATA_W(W), .MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_in(id_valid_in), .exe_allowin_out(exe_allowin_out),
    .mem_allowin_in(mem_allowin_in), .exe_valid_out(exe_valid_out), .flush_in(flush_in),
    .id_aluop_in(id_aluop_in), .id_src0_in(id_src0_in), .id_src1_in(id_src1_in),
    .id_md_op_in(id_md_op_in), .id_rd_hilo_in(id_rd_hilo_in), .id_regnum_in(id_regnum_in),
    .exe_res_out(exe_res_out), .exe_regnum_out(exe_regnum_out), .exe_hi_out(exe_hi_out),
    .exe_lo_out(exe_lo_out), .exe_busy_out(exe_busy_out)
  );

  localparam logic [5:0] MULT = 6'b100000, MULTU = 6'b010000, DIV = 6'b001000;
  localparam logic [5:0] DIVU = 6'b000100, MTHI = 6'b000010, MTLO = 6'b000001;

  typedef struct { logic [W-1:0] res; logic [4:0] rd; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int waits_last = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: r = (a < b) ? 32'd1 : 32'd0;
      4: r = a & b;
      5: r = ~(a | b);
      6: r = a | b;
      7: r = a ^ b;
      8: r = b << a[4:0];
      9: r = b >> a[4:0];
      10: r = $signed(b) >>> a[4:0];
      11: r = {b[15:0], 16'h0000};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void mul_ref(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic signed [63:0] ea, eb;
    logic [63:0] p;
    if (sgn) begin
      ea = $signed(a);
      eb = $signed(b);
      p  = ea * eb;
    end else begin
      p = {32'h0, a} * {32'h0, b};
    end
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  function automatic void div_ref(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo, output int cyc);
    logic signed [W-1:0] sa, sbv;
    logic [W-1:0] ma, mb;
    sa = a;
    sbv = b;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    if (b == 0) begin
      lo = '1;
      hi = a;
    end else if (sgn) begin
      lo = sa / sbv;
      hi = sa % sbv;
    end else begin
      lo = a / b;
      hi = a % b;
    end
    cyc = (SKIP && (b == 0 || ma < mb)) ? 1 : W;
  endfunction

  task automatic send(input logic [11:0] aop, input logic [5:0] md, input logic [1:0] hl,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp_res);
    int n = 0;
    logic [4:0] rd;
    rd = 5'($urandom_range(0, 31));
    @(negedge clk);
    id_aluop_in = aop; id_md_op_in = md; id_rd_hilo_in = hl;
    id_src0_in = a; id_src1_in = b; id_regnum_in = rd; id_valid_in = 1'b1;
    #1;
    while (!exe_allowin_out && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 200) check("allowin_timeout", n, 0);
    waits_last = n;
    sb.push_back('{exp_res, rd});
    @(posedge clk); #1;
    id_valid_in = 1'b0;
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    repeat (100) begin
      @(negedge clk); #1;
      if (!exe_busy_out) break;
      n++;
    end
  endtask

  task automatic do_md(input string tag, input logic [5:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ehi, input logic [W-1:0] elo, input int ebusy);
    int n;
    send(12'h000, md, 2'b00, a, b, '0);
    busy_cycles(n);
    check({tag, "_busy"}, n, ebusy);
    check({tag, "_hi"}, exe_hi_out, ehi);
    check({tag, "_lo"}, exe_lo_out, elo);
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && exe_valid_out && mem_allowin_in) begin
      if (sb.size() == 0) check("sb_unexpected", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("res", exe_res_out, e.res);
        check("regnum", exe_regnum_out, e.rd);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b, ehi, elo, hi0, lo0;
    int op, cyc;
    logic sgn;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", exe_valid_out, 0);
    check("rst_allowin", exe_allowin_out, 1);
    check("rst_busy", exe_busy_out, 0);
    check("rst_res", exe_res_out, 0);
    check("rst_regnum", exe_regnum_out, 0);
    check("rst_hi", exe_hi_out, 0);
    check("rst_lo", exe_lo_out, 0);
    rst_n = 1'b1;

    send(12'h001, 6'h0, 2'b00, 32'd7, 32'd5, 32'd12);
    check("add_next_cycle_valid", exe_valid_out, 1);
    send(12'h002, 6'h0, 2'b00, 32'd5, 32'd7, 32'hFFFF_FFFE);
    check("alu_nostall", waits_last, 0);
    send(12'h004, 6'h0, 2'b00, 32'h8000_0000, 32'd1, 32'd1);
    send(12'h008, 6'h0, 2'b00, 32'h8000_0000, 32'd1, 32'd0);
    send(12'h400, 6'h0, 2'b00, 32'd4, 32'h8000_0000, 32'hF800_0000);
    send(12'h800, 6'h0, 2'b00, 32'd0, 32'h0000_1234, 32'h1234_0000);
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 11);
      a = $urandom;
      b = $urandom;
      send(12'h001 << op, 6'h0, 2'b00, a, b, alu_ref(op, a, b));
      check("alu_nostall", waits_last, 0);
    end

    do_md("mult_m3x4", MULT, -32'sd3, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 2);
    send(12'h000, 6'h0, 2'b01, '0, '0, 32'hFFFF_FFF4);
    check("mflo_nostall", waits_last, 0);
    send(12'h000, 6'h0, 2'b10, '0, '0, 32'hFFFF_FFFF);
    do_md("multu", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 2);
    for (int i = 0; i < 4; i++) begin
      sgn = i[0];
      a = $urandom; b = $urandom;
      mul_ref(sgn, a, b, ehi, elo);
      do_md("mult_rand", sgn ? MULT : MULTU, a, b, ehi, elo, 2);
    end

    // Back-to-back multiplies: the second enters MUL straight from DONE.
    mul_ref(1'b1, 32'd9, 32'd11, ehi, elo);
    send(12'h000, MULT, 2'b00, 32'd5, 32'd6, '0);
    do_md("mult_chain", MULT, 32'd9, 32'd11, ehi, elo, 2);

    do_md("div_m7_2", DIV, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W);
    div_ref(1'b0, 32'd7, 32'd0, ehi, elo, cyc);
    do_md("divu_7_0", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, cyc);
    div_ref(1'b1, -32'sd5, 32'd0, ehi, elo, cyc);
    do_md("div_m5_0", DIV, -32'sd5, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, cyc);
    div_ref(1'b0, 32'd3, 32'd9, ehi, elo, cyc);
    do_md("divu_3_9", DIVU, 32'd3, 32'd9, 32'd3, 32'd0, cyc);
    for (int i = 0; i < 6; i++) begin
      sgn = i[0];
      a = $urandom;
      b = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      if (a == 32'h8000_0000) a = 32'h8000_0001;
      div_ref(sgn, a, b, ehi, elo, cyc);
      do_md("div_rand", sgn ? DIV : DIVU, a, b, ehi, elo, cyc);
    end

    send(12'h000, MTHI, 2'b00, 32'h1234_5678, '0, '0);
    send(12'h000, MTLO, 2'b00, 32'h9ABC_DEF0, '0, '0);
    send(12'h000, 6'h0, 2'b10, '0, '0, 32'h1234_5678);
    check("mtlo_no_stall", waits_last, 0);
    send(12'h000, 6'h0, 2'b01, '0, '0, 32'h9ABC_DEF0);

    // Abort a divide at its tenth cycle.
    hi0 = 32'h1234_5678; lo0 = 32'h9ABC_DEF0;
    send(12'h000, DIV, 2'b00, 32'd100, 32'd3, '0);
    repeat (10) @(negedge clk);
    flush_in = 1'b1;
    @(posedge clk); #1;
    flush_in = 1'b0;
    void'(sb.pop_back());
    check("flush_busy", exe_busy_out, 0);
    check("flush_allowin", exe_allowin_out, 1);
    check("flush_valid", exe_valid_out, 0);
    repeat (30) @(negedge clk);
    #1;
    check("flush_hi", exe_hi_out, hi0);
    check("flush_lo", exe_lo_out, lo0);

    // Flush beats a simultaneous incoming instruction.
    @(negedge clk);
    id_aluop_in = 12'h001; id_md_op_in = MTHI; id_src0_in = 32'hDEAD_BEEF; id_valid_in = 1'b1; flush_in = 1'b1;
    @(posedge clk); #1;
    id_valid_in = 1'b0; flush_in = 1'b0;
    check("flush_drop_valid", exe_valid_out, 0);
    repeat (2) @(negedge clk);
    #1;
    check("flush_drop_hi", exe_hi_out, hi0);

    // Downstream stall while holding a finished multiply.
    mem_allowin_in = 1'b0;
    do_md("mult_stall", MULT, 32'd6, 32'd7, 32'd0, 32'd42, 2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      check("stall_valid", exe_valid_out, 1);
      check("stall_allowin", exe_allowin_out, 0);
      check("stall_lo", exe_lo_out, 32'd42);
    end
    mem_allowin_in = 1'b1;
    send(12'h000, 6'h0, 2'b01, '0, '0, 32'd42);

    // Reset mid-multiply abandons the write.
    send(12'h000, MULT, 2'b00, 32'd3, 32'd3, '0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    #1;
    check("mulrst_busy", exe_busy_out, 0);
    check("mulrst_lo", exe_lo_out, 0);
    check("mulrst_valid", exe_valid_out, 0);

    repeat (20) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    check("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
